// File: rtl/sma_pkg.sv
// rtl/sma_pkg.sv - shared widths, FSM states and decimation-exponent clamp for the SMA sample feeder
package sma_pkg;
  localparam int DATA_W       = 32;
  localparam int MAX_DEC_LOG2 = 8;
  localparam int ACC_W        = 48;
  localparam int K_W          = 4;
  localparam int CNT_W        = MAX_DEC_LOG2 + 1;

  typedef enum logic {
    LOAD = 1'b0,
    ACC  = 1'b1
  } feeder_state_e;

  function automatic logic [K_W-1:0] clamp_dec(input logic [31:0] sel);
    if (sel > 32'(MAX_DEC_LOG2)) return K_W'(MAX_DEC_LOG2);
    return sel[K_W-1:0];
  endfunction
endpackage

// File: rtl/sma_sample_feeder_if.sv
// rtl/sma_sample_feeder_if.sv - raw-sample input and SMA update output bundle of the sample feeder
interface sma_sample_feeder_if;
  import sma_pkg::*;

  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic [31:0]       i_dec_sel;
  logic [31:0]       i_window_sel;
  logic              o_update_strobe;
  logic [DATA_W-1:0] o_data;
  logic [31:0]       o_window_sel;
  logic [K_W-1:0]    o_dec_active;
  logic              o_cfg_pending;

  modport master (
    output i_valid, i_data, i_dec_sel, i_window_sel,
    input  o_update_strobe, o_data, o_window_sel, o_dec_active, o_cfg_pending
  );

  modport slave (
    input  i_valid, i_data, i_dec_sel, i_window_sel,
    output o_update_strobe, o_data, o_window_sel, o_dec_active, o_cfg_pending
  );
endinterface

// File: rtl/sma_feeder_acc.sv
// rtl/sma_feeder_acc.sv - boxcar accumulator, sample counter and shift datapath of the feeder
// Optional SMA_FEEDER_ROUND_EN: round half up instead of floor when dividing by 2^k.
module sma_feeder_acc
  import sma_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [K_W-1:0]    i_k,
  output logic              o_last,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_result
);
  logic signed [ACC_W-1:0] acc_q, acc_d, sum, sum_rnd;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_last;

  assign sum      = acc_q + ACC_W'($signed(i_data));
  assign cnt_last = (CNT_W'(1) << i_k) - CNT_W'(1);
  assign o_last   = i_valid && (cnt_q == cnt_last);
  assign o_empty  = (cnt_q == '0);

`ifdef SMA_FEEDER_ROUND_EN
  // Half of 2^k; collapses to zero for k=0 so pass-through is untouched.
  assign sum_rnd = sum + $signed((ACC_W'(1) << i_k) >> 1);
`else
  assign sum_rnd = sum;
`endif

  assign o_result = DATA_W'(sum_rnd >>> i_k);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clear || o_last) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (i_valid) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sma_sample_feeder.sv
// rtl/sma_sample_feeder.sv - decimating writer of the SMA update interface; config reloads only on block boundaries
// Optional SMA_FEEDER_ROUND_EN (in sma_feeder_acc): round half up on decimation.
module sma_sample_feeder
  import sma_pkg::*;
(
  input logic                i_clk,
  input logic                i_rst_n,
  sma_sample_feeder_if.slave bus
);
  feeder_state_e     state_q, state_d;
  logic [K_W-1:0]    k_q, k_req;
  logic [31:0]       win_q;
  logic [DATA_W-1:0] data_q, result;
  logic              strobe_q, pending_q;
  logic              load, acc_valid, last, empty, cfg_diff;

  assign k_req     = clamp_dec(bus.i_dec_sel);
  assign cfg_diff  = (k_req != k_q) || (bus.i_window_sel != win_q);
  assign load      = (state_q == LOAD);
  assign acc_valid = (state_q == ACC) && bus.i_valid;

  sma_feeder_acc u_acc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (load),
    .i_valid  (acc_valid),
    .i_data   (bus.i_data),
    .i_k      (k_q),
    .o_last   (last),
    .o_empty  (empty),
    .o_result (result)
  );

  // Reload only at a block boundary or while nothing has been accumulated yet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: state_d = ACC;
      ACC: begin
        if (last) begin
          if (cfg_diff) state_d = LOAD;
        end else if (empty && !bus.i_valid && cfg_diff) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= LOAD;
      k_q       <= '0;
      win_q     <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= last;
      pending_q <= cfg_diff;
      if (load) begin
        k_q   <= k_req;
        win_q <= bus.i_window_sel;
      end
      if (last) data_q <= result;
    end
  end

  assign bus.o_update_strobe = strobe_q;
  assign bus.o_data          = data_q;
  assign bus.o_window_sel    = win_q;
  assign bus.o_dec_active    = k_q;
  assign bus.o_cfg_pending   = pending_q;
endmodule

// File: tb/tb_sma_sample_feeder.sv
// tb/tb_sma_sample_feeder.sv - randomized self-checking bench for sma_sample_feeder against a queue-based reference
module tb_sma_sample_feeder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   strobe_seen = 0;

  sma_sample_feeder_if bus ();

  sma_sample_feeder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  bit          m_loading;
  int          m_k;
  logic [31:0] m_win;
  longint      m_block[$];
  bit          m_strobe;
  longint      m_data;
  bit          m_pending;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampk(input logic [31:0] sel);
    return (sel > 32'd8) ? 8 : int'(sel);
  endfunction

  // Floor division by 2^k (or round half up when rounding is built in).
  function automatic longint expected_avg(input longint sum, input int k);
    longint d, n, q;
    int     t;
    d = longint'(1) << k;
    n = sum;
`ifdef SMA_FEEDER_ROUND_EN
    if (k > 0) n = sum + d / 2;
`endif
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    t = int'(q);
    return longint'(t);
  endfunction

  function automatic void model_step(input bit rst, input bit valid, input logic [31:0] data,
                                     input logic [31:0] dec, input logic [31:0] win);
    bit     diff;
    longint sum;
    if (!rst) begin
      m_loading = 1'b1;
      m_k       = 0;
      m_win     = '0;
      m_block.delete();
      m_strobe  = 1'b0;
      m_data    = 0;
      m_pending = 1'b0;
    end else begin
      diff      = (clampk(dec) != m_k) || (win != m_win);
      m_pending = diff;
      m_strobe  = 1'b0;
      if (m_loading) begin
        m_k       = clampk(dec);
        m_win     = win;
        m_block.delete();
        m_loading = 1'b0;
      end else if (valid) begin
        m_block.push_back(longint'($signed(data)));
        if (m_block.size() == (1 << m_k)) begin
          sum = 0;
          foreach (m_block[i]) sum += m_block[i];
          m_data    = expected_avg(sum, m_k);
          m_strobe  = 1'b1;
          m_block.delete();
          m_loading = diff;
        end
      end else if (m_block.size() == 0 && diff) begin
        m_loading = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    check("strobe", longint'(bus.o_update_strobe), longint'(m_strobe));
    check("data", longint'($signed(bus.o_data)), m_data);
    check("window", longint'(bus.o_window_sel), longint'(m_win));
    check("dec_active", longint'(bus.o_dec_active), longint'(m_k));
    check("pending", longint'(bus.o_cfg_pending), longint'(m_pending));
  endtask

  task automatic cycle(input bit v, input logic [31:0] d);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    model_step(rst_n, v, d, bus.i_dec_sel, bus.i_window_sel);
    #1;
    if (bus.o_update_strobe) strobe_seen++;
    compare_all();
  endtask

  initial begin
    logic [31:0] v;
    int          s0;
    int          exp3;

    rst_n            = 1'b0;
    bus.i_valid      = 1'b0;
    bus.i_data       = '0;
    bus.i_dec_sel    = '0;
    bus.i_window_sel = '0;
    cycle(0, 0);
    cycle(0, 0);
    check("reset_strobe", longint'(bus.o_update_strobe), 0);
    check("reset_data", longint'(bus.o_data), 0);
    check("reset_window", longint'(bus.o_window_sel), 0);
    check("reset_dec", longint'(bus.o_dec_active), 0);
    check("reset_pending", longint'(bus.o_cfg_pending), 0);

    rst_n            = 1'b1;
    bus.i_dec_sel    = 32'd2;
    bus.i_window_sel = 32'd64;
    cycle(0, 0);
    cycle(1, 32'd4);
    cycle(1, 32'd8);
    cycle(1, 32'd12);
    check("t1_no_early_strobe", longint'(bus.o_update_strobe), 0);
    cycle(1, 32'd16);
    check("t1_strobe", longint'(bus.o_update_strobe), 1);
    check("t1_data", longint'($signed(bus.o_data)), 10);
    check("t1_window", longint'(bus.o_window_sel), 64);
    cycle(0, 0);
    check("t1_single_pulse", longint'(bus.o_update_strobe), 0);

    cycle(1, -32'sd1); cycle(1, -32'sd2); cycle(1, -32'sd2); cycle(1, -32'sd2);
    check("t2_neg", longint'($signed(bus.o_data)), -2);
    cycle(1, 32'd1); cycle(1, 32'd1); cycle(1, 32'd1); cycle(1, 32'd2);
    check("t2_five", longint'($signed(bus.o_data)), 1);
`ifdef SMA_FEEDER_ROUND_EN
    exp3 = 2;
`else
    exp3 = 1;
`endif
    cycle(1, 32'd1); cycle(1, 32'd2); cycle(1, 32'd2); cycle(1, 32'd2);
    check("t2_seven", longint'($signed(bus.o_data)), longint'(exp3));

    bus.i_dec_sel = 32'd0;
    cycle(0, 0);
    cycle(0, 0);
    check("t3_dec", longint'(bus.o_dec_active), 0);
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 32'h7FFF_FFFF : (i == 1) ? 32'h8000_0000 : $urandom;
      cycle(1, v);
      check("t3_pass_strobe", longint'(bus.o_update_strobe), 1);
      check("t3_pass_data", longint'($signed(bus.o_data)), longint'($signed(v)));
    end

    bus.i_dec_sel = 32'd3;
    cycle(0, 0);
    cycle(0, 0);
    for (int i = 0; i < 3; i++) cycle(1, $urandom);
    bus.i_dec_sel = 32'd1;
    cycle(1, $urandom);
    check("t4_pending", longint'(bus.o_cfg_pending), 1);
    check("t4_k_held", longint'(bus.o_dec_active), 3);
    for (int i = 0; i < 4; i++) cycle(1, $urandom);
    check("t4_block8_strobe", longint'(bus.o_update_strobe), 1);
    cycle(1, $urandom);
    check("t4_k_new", longint'(bus.o_dec_active), 1);
    check("t4_load_no_strobe", longint'(bus.o_update_strobe), 0);
    s0 = strobe_seen;
    for (int i = 0; i < 6; i++) cycle(1, $urandom);
    check("t4_ratio2_strobes", longint'(strobe_seen - s0), 3);

    cycle(1, $urandom);
    bus.i_window_sel = 32'd128;
    cycle(1, $urandom);
    check("t5_strobe", longint'(bus.o_update_strobe), 1);
    check("t5_window_old", longint'(bus.o_window_sel), 64);
    cycle(0, 0);
    check("t5_window_new", longint'(bus.o_window_sel), 128);

    bus.i_dec_sel = 32'd20;
    cycle(0, 0);
    cycle(0, 0);
    check("t6_clamp", longint'(bus.o_dec_active), 8);
    s0 = strobe_seen;
    for (int i = 0; i < 256; i++) cycle(1, $urandom);
    check("t6_one_strobe", longint'(strobe_seen - s0), 1);
    for (int i = 0; i < 100; i++) cycle(1, $urandom);
    rst_n = 1'b0;
    cycle(1, $urandom);
    check("t6_rst_strobe", longint'(bus.o_update_strobe), 0);
    check("t6_rst_data", longint'(bus.o_data), 0);
    check("t6_rst_window", longint'(bus.o_window_sel), 0);
    check("t6_rst_dec", longint'(bus.o_dec_active), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.i_dec_sel    = $urandom_range(0, 10);
        bus.i_window_sel = $urandom_range(0, 3) * 64;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sma_sample_feeder.md
Name: sma_sample_feeder

Overview:
- Writer side of the moving-average update interface: produces the `update_strobe`, `data` and `window_sel` signals that the SMA block consumes.
- Takes raw signed gyro samples (valid-qualified) and boxcar-decimates them by a power of two.
- Emits one single-cycle update strobe per decimated sample.
- Applies decimation and window-select reconfiguration only on block boundaries, so the downstream SMA never sees a partial block.

Parameters:
- DATA_W, 32, sample and output width (signed).
- MAX_DEC_LOG2, 8, largest decimation exponent (max ratio 256).
- ACC_W, 48, accumulator width; must be at least DATA_W+MAX_DEC_LOG2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  raw sample qualifier; may be high every cycle.
- i_data  in  DATA_W  signed raw sample.
- i_dec_sel  in  32  requested decimation exponent k (ratio 2^k); values above MAX_DEC_LOG2 clamp to MAX_DEC_LOG2.
- i_window_sel  in  32  requested SMA window select.
- o_update_strobe  out  1  one-cycle pulse, decimated sample valid.
- o_data  out  DATA_W  signed decimated sample, held between strobes.
- o_window_sel  out  32  active window select driven to the SMA.
- o_dec_active  out  4  active decimation exponent (debug).
- o_cfg_pending  out  1  a requested config differs from the active one.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - o_update_strobe=0, o_data=0, o_window_sel=0, o_dec_active=0, o_cfg_pending=0.
  - Accumulator=0, sample counter=0, FSM=LOAD.
- FSM states: LOAD, ACC.
  - LOAD, one cycle:
    - Latch clamped i_dec_sel into the active k and i_window_sel into o_window_sel.
    - Clear the accumulator and counter; go to ACC.
    - i_valid in the LOAD cycle is dropped. This is the only cycle in which samples are lost.
  - ACC:
    - On each i_valid, accumulator += sign-extended i_data and counter++.
    - When the valid that makes counter == 2^k arrives (the last sample):
      - o_data <= (accumulator + i_data) >>> k, arithmetic shift, truncated to DATA_W. The quotient always fits DATA_W.
      - o_update_strobe=1 on the next cycle, for exactly one cycle.
      - Counter and accumulator clear. A valid on the following cycle starts the new block with no bubble.
    - At that same boundary, if config is pending, the next state is LOAD; otherwise stay in ACC.
- Latency: strobe and new o_data appear 1 clock after the clock edge that samples the last valid of a block.
- k=0 (ratio 1): every valid produces o_data=i_data with a strobe 1 clock later (pass-through).
- Config change:
  - o_cfg_pending = (clamp(i_dec_sel) != active k) OR (i_window_sel != o_window_sel), registered.
  - A change mid-block never alters the active k or o_window_sel until the block completes.
  - A change that reverts before the boundary causes no reload.
  - Change while in ACC with counter==0 (nothing accumulated): reload on the next cycle.
- Simultaneous last-sample valid and config change: the block completes with the old k and strobes; the new config loads in the following LOAD cycle.
- o_window_sel changes only in LOAD, never in the same cycle as a strobe.
- Reset mid-block: partial sums are discarded and no strobe is issued.

Optional Feature:
- Macro SMA_FEEDER_ROUND_EN.
  - Defined: o_data = (sum + 2^(k-1)) >>> k for k>0, i.e. round half up; k=0 is unchanged.
  - Undefined: plain arithmetic shift (floor).

Decomposition:
- Shared package `sma_pkg`:
  - DATA_W, MAX_DEC_LOG2 and ACC_W constants.
  - FSM state typedef {LOAD, ACC}.
  - A clamp function for the decimation exponent.
- One natural sub-module, `sma_feeder_acc`: the accumulator, counter and rounding/shift datapath, with a last-sample flag output. The FSM and config compare stay in the top.

Test Plan:
1. Reset, then k=2, window_sel=64, valids with data 4,8,12,16 back-to-back -> one strobe with o_data=10, 1 clock after the 4th sample; o_window_sel=64.
2. k=2, data -1,-2,-2,-2 (sum -7) -> o_data=-2 without SMA_FEEDER_ROUND_EN; o_data=-2 with it (-7+2 = -5, >>>2 = -2); also 1,1,1,2 -> 1 without, 1 with; 1,2,2,2 -> 1 without, 2 with.
3. k=0, 8 consecutive valids 0x7FFFFFFF, 0x80000000, ... -> 8 strobes, each o_data equal to its input, 1 clock latency, no gaps.
4. k=3; change i_dec_sel to 1 after the 3rd sample -> o_cfg_pending=1; the 8-sample block completes with ratio 8; LOAD drops one valid; the next strobes occur every 2 valids.
5. Window_sel change 64->128 coinciding with the last-sample valid -> strobe carries the old-k result; o_window_sel becomes 128 one cycle after the strobe cycle.
6. i_dec_sel=20 -> o_dec_active=8 and a strobe every 256 valids; assert i_rst_n=0 after 100 valids -> no strobe, all outputs 0 on the next edge.
